// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared widths, per-stage lane structs and the S4 saturating shift for exp_vec
package exp_pkg;

  localparam int EXP_LATENCY = 4;

  // Lane widths. The lane datapath is built for EXP_D_W bits; the top-level
  // D_W parameter must equal it.
  localparam int EXP_D_W  = 32;
  localparam int EXP_Z_W  = 2*EXP_D_W + 1;  // (D_W+1) x D_W product
  localparam int EXP_R_W  = EXP_D_W + 1;    // r fits (-qln2, 0] plus headroom
  localparam int EXP_P_W  = 2*EXP_D_W + 2;  // poly = r*(r+qb)+qc
  localparam int EXP_SH_W = $clog2(2*EXP_D_W);

  localparam logic [EXP_P_W-1:0] EXP_E_MAX =
    {{(EXP_P_W-EXP_D_W+1){1'b0}}, {(EXP_D_W-1){1'b1}}};

  typedef struct packed {
    logic signed [EXP_D_W-1:0] x;
    logic        [EXP_Z_W-1:0] z;
  } exp_s1_t;

  typedef struct packed {
    logic signed [EXP_R_W-1:0] r;
    logic        [EXP_Z_W-1:0] z;
  } exp_s2_t;

  typedef struct packed {
    logic signed [EXP_P_W-1:0] poly;
    logic        [EXP_Z_W-1:0] z;
  } exp_s3_t;

  // e = poly >>> z, forced to 0 for negative poly or shifts that clear every
  // bit, and clipped to the largest positive D_W-bit value.
  function automatic logic [EXP_D_W-1:0] exp_sat_shift(
    input logic signed [EXP_P_W-1:0] poly,
    input logic        [EXP_Z_W-1:0] z
  );
    logic signed [EXP_P_W-1:0] sh;
    sh = '0;
    if (poly[EXP_P_W-1] || (z >= EXP_Z_W'(2*EXP_D_W))) begin
      exp_sat_shift = '0;
    end else begin
      sh = poly >>> z[EXP_SH_W-1:0];
      if (sh > $signed(EXP_E_MAX)) begin
        exp_sat_shift = EXP_E_MAX[EXP_D_W-1:0];
      end else begin
        exp_sat_shift = sh[EXP_D_W-1:0];
      end
    end
  endfunction

endpackage

// File: rtl/exp_lane.sv
// rtl/exp_lane.sv - one lane of the i-exp datapath, stages S1..S4 with a common hold
// Ports: clk, rst (async active-low), hold (freeze all stages), qin (lane input),
//        qb/qc/qln2/qln2_inv (coefficients, read in the stage that uses them),
//        qout (S4 register, e >= 0).
module exp_lane
  import exp_pkg::*;
#(
  parameter int FP_BITS = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic signed [EXP_D_W-1:0] qin,
  input  logic signed [EXP_D_W-1:0] qb,
  input  logic signed [EXP_D_W-1:0] qc,
  input  logic signed [EXP_D_W-1:0] qln2,
  input  logic signed [EXP_D_W-1:0] qln2_inv,
  output logic        [EXP_D_W-1:0] qout
);

  localparam int D = EXP_D_W;
  localparam int Z = EXP_Z_W;
  localparam int R = EXP_R_W;
  localparam int P = EXP_P_W;

  exp_s1_t s1_d, s1_q;
  exp_s2_t s2_d, s2_q;
  exp_s3_t s3_d, s3_q;
  logic [D-1:0] e_d, e_q;

  // S1: clamp, negate in D+1 bits, z = (n * qln2_inv) >> FP_BITS (logical).
  logic signed [D-1:0] x;
  logic [D:0]   n;
  logic [Z-1:0] n_e, qi_e, prod;
  always_comb begin
    x    = qin[D-1] ? qin : '0;
    n    = -{x[D-1], x};
    n_e  = {{(Z-D-1){n[D]}}, n};
    qi_e = {{(Z-D){qln2_inv[D-1]}}, qln2_inv};
    prod = n_e * qi_e;
    s1_d.x = x;
    s1_d.z = prod >> FP_BITS;
  end

  // S2: r = x + z*qln2. Only the low R bits of the product can reach r, so
  // the multiply is done modulo 2^R.
  logic [R-1:0] x_e, z_lo, ql_e, r;
  always_comb begin
    x_e  = {s1_q.x[D-1], s1_q.x};
    z_lo = s1_q.z[R-1:0];
    ql_e = {qln2[D-1], qln2};
    r    = x_e + z_lo * ql_e;
    s2_d.r = r;
    s2_d.z = s1_q.z;
  end

  // S3: poly = r*(r+qb)+qc at full 2*D+2 width.
  logic [P-1:0] r_e, qb_e, qc_e;
  always_comb begin
    r_e  = {{(P-R){s2_q.r[R-1]}}, s2_q.r};
    qb_e = {{(P-D){qb[D-1]}}, qb};
    qc_e = {{(P-D){qc[D-1]}}, qc};
    s3_d.poly = r_e * (r_e + qb_e) + qc_e;
    s3_d.z    = s2_q.z;
  end

  // S4
  always_comb begin
    e_d = exp_sat_shift(s3_q.poly, s3_q.z);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      e_q  <= '0;
    end else if (!hold) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      e_q  <= e_d;
    end
  end

  assign qout = e_q;

endmodule

// File: rtl/exp_vec.sv
// rtl/exp_vec.sv - LANES-wide pipelined integer exp with valid/ready and optional row sum
// Ports: clk, rst (async active-low), in_valid/in_ready/in_last/qin (input beats),
//        qb/qc/qln2/qln2_inv (quasi-static coefficients),
//        out_valid/out_ready/out_last/qout (output beats, 4-cycle latency),
//        sum_valid/row_sum (only with EXP_ROWSUM_EN defined).
// Build option: EXP_ROWSUM_EN adds the saturating per-row sum of exponentials.
module exp_vec
  import exp_pkg::*;
#(
  parameter int D_W     = EXP_D_W,
  parameter int FP_BITS = 30,
`ifdef EXP_ROWSUM_EN
  parameter int SUM_W   = 48,
`endif
  parameter int LANES   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*D_W-1:0]   qin,
  input  logic [D_W-1:0]         qb,
  input  logic [D_W-1:0]         qc,
  input  logic [D_W-1:0]         qln2,
  input  logic [D_W-1:0]         qln2_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
`ifdef EXP_ROWSUM_EN
  output logic                   sum_valid,
  output logic [SUM_W-1:0]       row_sum,
`endif
  output logic [LANES*D_W-1:0]   qout
);

  localparam int L = EXP_LATENCY;

  logic [L-1:0] vld_d, vld_q, lst_d, lst_q;
  logic         stall;

  // The whole pipe, bubbles included, freezes while the output beat waits.
  always_comb begin
    stall = vld_q[L-1] && !out_ready;
    vld_d = vld_q;
    lst_d = lst_q;
    if (!stall) begin
      vld_d = {vld_q[L-2:0], in_valid};
      lst_d = {lst_q[L-2:0], in_last};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= vld_d;
      lst_q <= lst_d;
    end
  end

  assign in_ready  = !stall;
  assign out_valid = vld_q[L-1];
  assign out_last  = lst_q[L-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    exp_lane #(.FP_BITS(FP_BITS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .hold     (stall),
      .qin      (qin[i*D_W +: D_W]),
      .qb       (qb),
      .qc       (qc),
      .qln2     (qln2),
      .qln2_inv (qln2_inv),
      .qout     (qout[i*D_W +: D_W])
    );
  end

`ifdef EXP_ROWSUM_EN
  logic [SUM_W-1:0] acc_d, acc_q, row_sum_d, row_sum_q, lane_sum, sat_sum;
  logic [SUM_W:0]   tot;
  logic             sum_valid_d, sum_valid_q, out_acc;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SUM_W'($unsigned(qout[i*D_W +: D_W]));
    end
    tot         = {1'b0, acc_q} + {1'b0, lane_sum};
    sat_sum     = tot[SUM_W] ? '1 : tot[SUM_W-1:0];
    out_acc     = out_valid && out_ready;
    acc_d       = acc_q;
    row_sum_d   = row_sum_q;
    sum_valid_d = 1'b0;
    if (out_acc) begin
      if (out_last) begin
        row_sum_d   = sat_sum;
        sum_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = sat_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      row_sum_q   <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      row_sum_q   <= row_sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_valid = sum_valid_q;
  assign row_sum   = row_sum_q;
`endif

endmodule

// File: tb/tb_exp_vec.sv
// tb/tb_exp_vec.sv - scoreboard bench for exp_vec with hand-computed lane vectors
module tb_exp_vec;

  localparam int D_W = 32;
  localparam int LN  = 4;
  localparam int W   = D_W*LN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, in_ready, in_last;
  logic           out_valid, out_ready, out_last;
  logic [W-1:0]   qin, qout;
  logic [D_W-1:0] qb, qc, qln2, qln2_inv;
`ifdef EXP_ROWSUM_EN
  logic           sum_valid;
  logic [47:0]    row_sum;
`endif

  exp_vec dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .qin      (qin),
    .qb       (qb),
    .qc       (qc),
    .qln2     (qln2),
    .qln2_inv (qln2_inv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
`ifdef EXP_ROWSUM_EN
    .sum_valid(sum_valid),
    .row_sum  (row_sum),
`endif
    .qout     (qout)
  );

  // qln2=8, qln2_inv=2^27 (z = n>>3), qb=10, qc=100, worked by hand.
  int tin  [16] = '{0, -1, -2, -3, -5, -7, -8, -10, -12, -16, -20, -24, -100, 5, 100, 32'h80000000};
  int tout [16] = '{100, 91, 84, 79, 75, 79, 50, 42, 38, 25, 19, 12, 0, 100, 100, 0};

  typedef struct {
    logic [W-1:0] q;
    logic         last;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, req);
  endtask

  // out_ready changes 2 time units after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       out_ready = ($urandom_range(0, 1) == 1);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input int a, input int b, input int c, input int d,
                      input bit last, input bit lat);
    exp_t e;
    bit   acc;
    int   tries;
    qin    = {tin[d], tin[c], tin[b], tin[a]};
    e.q    = {tout[d], tout[c], tout[b], tout[a]};
    e.last = last;
    e.lat  = lat;
    e.cyc  = 0;
    in_valid = 1'b1;
    in_last  = last;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc   = in_ready;
      e.cyc = cyc;
      @(posedge clk);
      #1;
      tries++;
    end
    in_valid = 1'b0;
    check("accept_in_time", acc, 1);
    if (acc) sbq.push_back(e);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_q;
  logic         prev_last;
`ifdef EXP_ROWSUM_EN
  logic [47:0]  acc_m = '0;
  logic [47:0]  sum_m = '0;
  bit           sv_exp = 1'b0;
`endif

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
`ifdef EXP_ROWSUM_EN
      acc_m  = '0;
      sv_exp = 1'b0;
`endif
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_qout", qout, prev_q);
        check("hold_last", out_last, prev_last);
      end
`ifdef EXP_ROWSUM_EN
      check("sum_valid", sum_valid, sv_exp);
      if (sv_exp) check("row_sum", row_sum, sum_m);
      sv_exp = 1'b0;
`endif
      if (out_valid && out_ready) begin
        check("beat_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("qout", qout, mon_e.q);
          check("out_last", out_last, mon_e.last);
          if (mon_e.lat) check("latency", cyc - mon_e.cyc, 4);
`ifdef EXP_ROWSUM_EN
          for (int i = 0; i < LN; i++) acc_m = acc_m + 48'(mon_e.q[i*D_W +: D_W]);
          if (mon_e.last) begin
            sum_m  = acc_m;
            acc_m  = '0;
            sv_exp = 1'b1;
          end
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_q     = qout;
      prev_last  = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; qin = '0;
    qb = 10; qc = 100; qln2 = 8; qln2_inv = 32'h0800_0000;
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_qout", qout, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef EXP_ROWSUM_EN
    check("rst_sum_valid", sum_valid, 0);
    check("rst_row_sum", row_sum, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_in_ready", in_ready, 1);
    rst = 1'b1;

    // {0,-3,-8,5} -> {100,79,50,100}, then the most negative input.
    send(0, 3, 6, 13, 1'b0, 1'b1);
    wait_drain();
    send(15, 15, 15, 15, 1'b0, 1'b1);
    send(1, 2, 4, 5, 1'b1, 1'b1);
    wait_drain();

    // 8 beats with out_ready low for 6 cycles in the middle.
    fork
      begin
        for (int k = 0; k < 8; k++) send(k, k + 1, k + 2, k + 3, k == 7, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 rdy_mode = 2;
        repeat (6) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    wait_drain();

    // 3-beat all-zero row (1200), then a 1-beat row starting from 0 (400).
    send(0, 0, 0, 0, 1'b0, 1'b1);
    send(0, 0, 0, 0, 1'b0, 1'b1);
    send(0, 0, 0, 0, 1'b1, 1'b1);
    send(13, 13, 13, 13, 1'b1, 1'b1);
    wait_drain();

    // Random out_ready.
    rdy_mode = 1;
    for (int k = 0; k < 40; k++)
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 3) == 0, 1'b0);
    rdy_mode = 0;
    wait_drain();

    // Back-to-back at full rate: every beat must come out exactly 4 cycles later.
    for (int k = 0; k < 16; k++)
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), (k % 4) == 3, 1'b1);
    wait_drain();

    // Reset with one stalled output beat, three in flight and a partial row.
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) send(k + 4, k + 5, k + 6, k + 7, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_reset_valid", out_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_qout", qout, 0);
    check("mid_rst_out_last", out_last, 0);
`ifdef EXP_ROWSUM_EN
    check("mid_rst_sum_valid", sum_valid, 0);
    check("mid_rst_row_sum", row_sum, 0);
`endif
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_mode = 0;
    send(0, 0, 0, 0, 1'b0, 1'b1);
    send(0, 0, 0, 0, 1'b0, 1'b1);
    send(0, 0, 0, 0, 1'b1, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exp_vec.md
# exp_vec

Multi-lane, fully pipelined integer-only exponential (I-BERT i-exp) with valid/ready back-pressure, the successor to the single-lane exp unit. It processes `LANES` non-positive fixed-point inputs per beat at one beat per cycle, with fixed latency. It sits between the row-max subtractor and the softmax normaliser. It can optionally accumulate the per-row sum of exponentials that the normaliser needs.

## Interface
- `D_W`, 32: lane data width, signed.
- `FP_BITS`, 30: fractional bits of `qln2_inv`.
- `LANES`, 4: lanes per beat, ≥1.
- `SUM_W`, 48: row-sum width, unsigned; requires `SUM_W` ≥ `D_W`.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset; asynchronous assert, active-low.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: unit accepts a beat.
- `in_last`  in  1: beat is the last of a row.
- `qin`  in  `LANES*D_W`: packed signed inputs; lane `i` is bits `[i*D_W +: D_W]`.
- `qb`, `qc`, `qln2`, `qln2_inv`  in  `D_W` each: signed coefficients; quasi-static.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: downstream accepts.
- `out_last`  out  1: `in_last` delayed with its beat.
- `qout`  out  `LANES*D_W`: packed signed exp results, each ≥ 0.
- `sum_valid`  out  1: one-cycle row-sum strobe. Present only with `EXP_ROWSUM_EN`.
- `row_sum`  out  `SUM_W`: sum of all lanes of the finished row. Present only with `EXP_ROWSUM_EN`.

## Operation
Per lane, arithmetic is done at full width with no intermediate truncation:
- Clamp: `x = min(qin, 0)`. Positive inputs are treated as 0.
- S1: `n = -x`, computed in `D_W+1` bits so that the most negative input is safe. Then `z = (n * qln2_inv) >> FP_BITS`, a logical shift with `z` ≥ 0.
- S2: `r = x + z*qln2`. Valid coefficients give `r` in `(-qln2, 0]`.
- S3: `poly = r*(r + qb) + qc`, computed in `2*D_W+2` bits.
- S4: `e = (poly < 0) ? 0 : poly >>> z`.
  - If `z` ≥ `2*D_W`, `e = 0`.
  - If the result exceeds `2^(D_W-1)-1`, `e` saturates to that value.

Coefficients are sampled at the stage that uses them. The host changes them only while the pipe is empty.

Row sum (with `EXP_ROWSUM_EN`):
- The accumulator adds the lane sum of every accepted output beat, i.e. every cycle with `out_valid && out_ready`.
- The accumulator saturates at `2^SUM_W-1`.
- On an accepted beat with `out_last` set:
  - `row_sum` is loaded with accumulator + that beat's lane sum.
  - `sum_valid` pulses high for the next cycle only.
  - The accumulator clears.
- A single-beat row (`in_last` on every beat) produces one strobe per beat.

## Timing
- 4-stage pipeline S1..S4. The S4 register drives `qout`, `out_last`, `out_valid`.
- Latency is exactly 4 cycles from input acceptance to `out_valid` when unstalled. Throughput is 1 beat/cycle.
- `stall = out_valid && !out_ready`. When stalled, every stage holds, including bubbles; bubbles are not collapsed.
- `in_ready = !stall`, combinational. An input is accepted when `in_valid && in_ready`.
- `out_valid` stays high and `qout`/`out_last` stay stable until accepted.
- Reset values: all stage valids 0, `out_valid` 0, `qout` 0, `out_last` 0, `sum_valid` 0, `row_sum` 0, accumulator 0. `in_ready` is 1 during and after reset.
- Reset mid-row: in-flight beats are discarded, the partial sum is lost, and no strobe is issued.
- Simultaneous input acceptance and output acceptance is legal and requires no bubble.

## Configuration
- `EXP_ROWSUM_EN` defined: the accumulator, `sum_valid` and `row_sum` exist, as described above.
- Not defined: these ports and all associated logic are absent. `out_last` is still pipelined.

## Structure
- Package `exp_pkg` holds:
  - `EXP_LATENCY` = 4.
  - Per-stage lane struct typedefs (`x`, `z`, `r`, `poly`) parametrised via `localparam` widths derived from `D_W`.
  - The saturating-shift function.
- Sub-module `exp_lane`: one lane's S1–S4 datapath with a `hold` input. It is instantiated `LANES` times in a generate loop.
- The top level owns the valid/last shift chain, the handshake, and the row-sum accumulator.

## Test plan
All scenarios use `LANES`=4 and coefficients `qln2`=8, `qln2_inv`=2^27, `qb`=10, `qc`=100.
- Lane inputs {0, -3, -8, 5} -> `qout` {100, 79, 50, 100} exactly 4 cycles after acceptance.
- Most negative input -2^31 on all lanes -> `qout` all 0, with no X values or wrap.
- `out_ready` held low for 6 cycles while streaming 8 beats:
  - `in_ready` drops 0 cycles after `out_valid`&&!`out_ready`.
  - No beat is lost or duplicated, and order is preserved.
  - `qout` is stable while stalled.
- With `EXP_ROWSUM_EN`, a 3-beat row of all-0 inputs with `in_last` on beat 3 -> `sum_valid` one cycle after beat 3 is accepted, `row_sum` = 1200; the next row starts from 0.
- `rst` asserted with 3 beats in flight and a partial row -> `out_valid` 0 immediately, no `sum_valid`; after release, a fresh row sums correctly.
- Random stream with random `out_ready` against a behavioural model -> `qout`/`out_last` match bit-exactly, with back-to-back accept/issue at 100% throughput when `out_ready`=1.
